// File: rtl/elevator_scheduler.sv
// Four-floor elevator scheduler: latches hall/car calls, tracks the current
// floor from the landing sensors, and sequences the motor and door through an
// IDLE / MOVE_UP / MOVE_DN / DOOR state machine with collective-control
// direction preference.
module elevator_scheduler #(
  parameter int unsigned DOOR_TIME = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sensor,
  input  logic [3:0] hall_up,
  input  logic [3:0] hall_dn,
  input  logic [3:0] car_btn,
  output logic       up,
  output logic       down,
  output logic       stop,
  output logic       open_door,
  output logic [1:0] monitor,
  output logic [3:0] pending
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MOVE_UP = 2'd1,
    S_MOVE_DN = 2'd2,
    S_DOOR    = 2'd3
  } state_t;

  localparam logic [3:0] RELOAD = 4'(DOOR_TIME - 1);

  // Floors strictly above f.
  function automatic logic [3:0] above_mask(input logic [1:0] f);
    above_mask = 4'b1110 << f;
  endfunction

  // Floors strictly below f.
  function automatic logic [3:0] below_mask(input logic [1:0] f);
    below_mask = 4'b0111 >> (2'd3 - f);
  endfunction

  // Single floor f as a one-hot mask.
  function automatic logic [3:0] floor_mask(input logic [1:0] f);
    floor_mask = 4'b0001 << f;
  endfunction

  state_t     state_q, state_d;
  logic       dir_up_q, dir_up_d;
  logic [1:0] floor_q, floor_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] car_q, car_d;
  logic [3:0] hu_q, hu_d;
  logic [3:0] hd_q, hd_d;
  logic       up_q, up_d;
  logic       down_q, down_d;
  logic       stop_q, stop_d;
  logic       open_q, open_d;

  logic [3:0] calls_s;
  logic [3:0] hu_set_s;
  logic [3:0] hd_set_s;
  logic       floor_chg_s;
  logic       door_hit_s;
  logic       enter_door_s;
  logic [1:0] stop_f_s;
  logic [3:0] clr_car_s, clr_hu_s, clr_hd_s;
  logic [3:0] sup_car_s, sup_hu_s, sup_hd_s;

  // Top-floor up and bottom-floor down buttons do not exist.
  assign hu_set_s    = hall_up & 4'b0111;
  assign hd_set_s    = hall_dn & 4'b1110;
  assign calls_s     = car_q | hu_q | hd_q;
  assign floor_chg_s = (floor_d != floor_q);
  assign door_hit_s  = car_btn[floor_q] | (dir_up_q ? hu_set_s[floor_q] : hd_set_s[floor_q]);

  assign pending   = calls_s;
  assign monitor   = floor_q;
  assign up        = up_q;
  assign down      = down_q;
  assign stop      = stop_q;
  assign open_door = open_q;

  // Floor register follows a clean one-hot sensor, holds between floors or on glitches.
  always_comb begin
    floor_d = floor_q;
    case (sensor)
      4'b0001: floor_d = 2'd0;
      4'b0010: floor_d = 2'd1;
      4'b0100: floor_d = 2'd2;
      4'b1000: floor_d = 2'd3;
      default: floor_d = floor_q;
    endcase
  end

  // Next-state, direction and door-counter decisions.
  always_comb begin
    state_d      = state_q;
    dir_up_d     = dir_up_q;
    cnt_d        = cnt_q;
    enter_door_s = 1'b0;
    stop_f_s     = floor_q;
    case (state_q)
      S_IDLE: begin
        if (calls_s[floor_q]) begin
          enter_door_s = 1'b1;
        end else if ((|(calls_s & above_mask(floor_q))) &&
                     (dir_up_q || !(|(calls_s & below_mask(floor_q))))) begin
          state_d  = S_MOVE_UP;
          dir_up_d = 1'b1;
        end else if (|(calls_s & below_mask(floor_q))) begin
          state_d  = S_MOVE_DN;
          dir_up_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MOVE_UP: begin
        if (floor_chg_s) begin
          stop_f_s     = floor_d;
          enter_door_s = car_q[floor_d] | hu_q[floor_d] | (floor_d == 2'd3) |
                         !(|(calls_s & above_mask(floor_d)));
        end else if (floor_q == 2'd3) begin
          enter_door_s = 1'b1;
        end else begin
          enter_door_s = 1'b0;
        end
      end
      S_MOVE_DN: begin
        if (floor_chg_s) begin
          stop_f_s     = floor_d;
          enter_door_s = car_q[floor_d] | hd_q[floor_d] | (floor_d == 2'd0) |
                         !(|(calls_s & below_mask(floor_d)));
        end else if (floor_q == 2'd0) begin
          enter_door_s = 1'b1;
        end else begin
          enter_door_s = 1'b0;
        end
      end
      S_DOOR: begin
        if (door_hit_s) begin
          cnt_d = RELOAD;
        end else if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (enter_door_s) begin
      state_d = S_DOOR;
      cnt_d   = RELOAD;
    end else begin
      state_d = state_d;
    end
  end

  // Call-latch clear masks on door entry and press suppression while the door is open.
  always_comb begin
    clr_car_s = 4'b0000;
    clr_hu_s  = 4'b0000;
    clr_hd_s  = 4'b0000;
    sup_car_s = 4'b0000;
    sup_hu_s  = 4'b0000;
    sup_hd_s  = 4'b0000;
    if (enter_door_s) begin
      clr_car_s = floor_mask(stop_f_s);
      if (dir_up_q) begin
        clr_hu_s = floor_mask(stop_f_s);
        clr_hd_s = (|(calls_s & above_mask(stop_f_s))) ? 4'b0000 : floor_mask(stop_f_s);
      end else begin
        clr_hd_s = floor_mask(stop_f_s);
        clr_hu_s = (|(calls_s & below_mask(stop_f_s))) ? 4'b0000 : floor_mask(stop_f_s);
      end
    end else if (state_q == S_DOOR) begin
      sup_car_s = floor_mask(floor_q);
      sup_hu_s  = dir_up_q ? floor_mask(floor_q) : 4'b0000;
      sup_hd_s  = dir_up_q ? 4'b0000 : floor_mask(floor_q);
    end else begin
      clr_car_s = 4'b0000;
    end
  end

  // Latch next values and motor/door command decode of the next state.
  always_comb begin
    car_d  = (car_q | (car_btn & ~sup_car_s)) & ~clr_car_s;
    hu_d   = (hu_q | (hu_set_s & ~sup_hu_s)) & ~clr_hu_s;
    hd_d   = (hd_q | (hd_set_s & ~sup_hd_s)) & ~clr_hd_s;
    up_d   = 1'b0;
    down_d = 1'b0;
    stop_d = 1'b1;
    open_d = 1'b0;
    case (state_d)
      S_MOVE_UP: begin up_d = 1'b1; stop_d = 1'b0; end
      S_MOVE_DN: begin down_d = 1'b1; stop_d = 1'b0; end
      S_DOOR:    begin open_d = 1'b1; end
      S_IDLE:    begin stop_d = 1'b1; end
      default:   begin stop_d = 1'b1; end
    endcase
  end

  // All scheduler state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      dir_up_q <= 1'b1;
      floor_q  <= 2'd0;
      cnt_q    <= 4'd0;
      car_q    <= 4'b0000;
      hu_q     <= 4'b0000;
      hd_q     <= 4'b0000;
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      stop_q   <= 1'b1;
      open_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_up_q <= dir_up_d;
      floor_q  <= floor_d;
      cnt_q    <= cnt_d;
      car_q    <= car_d;
      hu_q     <= hu_d;
      hd_q     <= hd_d;
      up_q     <= up_d;
      down_q   <= down_d;
      stop_q   <= stop_d;
      open_q   <= open_d;
    end
  end

endmodule
